// File: rtl/tlc_conflict_monitor.sv
// tlc_conflict_monitor: safety stage between light controller and lamp drivers.
// Optional fault_count output when TLC_MON_FAULT_LOG_EN is defined.
module tlc_conflict_monitor #(
  parameter int MIN_YELLOW  = 3,
  parameter int FLASH_HALF  = 1,
  parameter int RECOVER_RED = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clr_fault,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [2:0] fault_code
`ifdef TLC_MON_FAULT_LOG_EN
  ,
  output logic [7:0] fault_count
`endif
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int RW = $clog2(RECOVER_RED + 1);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [YW-1:0] YMAX = YW'(MIN_YELLOW);
  localparam logic [RW-1:0] RMAX = RW'(RECOVER_RED);
  localparam logic [FW-1:0] FMAX = FW'(FLASH_HALF - 1);

  typedef enum logic {
    S_MONITOR = 1'b0,
    S_FAULT   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    in_w   [4];
  logic [2:0]    lamp_q [4];
  logic [2:0]    lamp_d [4];
  logic [2:0]    prev_q [4];
  logic [2:0]    prev_d [4];
  logic [YW-1:0] ycnt_q [4];
  logic [YW-1:0] ycnt_d [4];
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [2:0]    code_q, code_d, code_w;
  logic [3:0]    vld, grn;
  logic          bad_enc, grn_conf, y_skip, y_short, y_to_g;
  logic          all_red;

  assign in_w[0] = light_M1;
  assign in_w[1] = light_M2;
  assign in_w[2] = light_MT;
  assign in_w[3] = light_S;

  // Classify inputs against history; lowest violation code wins.
  always_comb begin
    vld     = '0;
    grn     = '0;
    bad_enc = 1'b0;
    y_skip  = 1'b0;
    y_short = 1'b0;
    y_to_g  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld[i] = (in_w[i] == RED) || (in_w[i] == YEL) || (in_w[i] == GRN);
      grn[i] = (in_w[i] == GRN);
      if (!vld[i])
        bad_enc = 1'b1;
      if (prev_q[i] == GRN && in_w[i] == RED)
        y_skip = 1'b1;
      if (prev_q[i] == YEL && in_w[i] == RED && ycnt_q[i] < YMAX)
        y_short = 1'b1;
      if (prev_q[i] == YEL && in_w[i] == GRN)
        y_to_g = 1'b1;
    end
    grn_conf = (grn[3] && (grn[0] || grn[1] || grn[2]))
             || (grn[1] && grn[2]);
    if (bad_enc)
      code_w = 3'd1;
    else if (grn_conf)
      code_w = 3'd2;
    else if (y_skip)
      code_w = 3'd3;
    else if (y_short)
      code_w = 3'd4;
    else if (y_to_g)
      code_w = 3'd5;
    else
      code_w = 3'd0;
  end

  // History, yellow run lengths and all-red run length, both states.
  always_comb begin
    all_red = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prev_d[i] = vld[i] ? in_w[i] : RED;
      ycnt_d[i] = '0;
      if (in_w[i] == YEL)
        ycnt_d[i] = (ycnt_q[i] == YMAX) ? YMAX : ycnt_q[i] + YW'(1);
      if (in_w[i] != RED)
        all_red = 1'b0;
    end
    rcnt_d = '0;
    if (all_red)
      rcnt_d = (rcnt_q == RMAX) ? RMAX : rcnt_q + RW'(1);
  end

  // Monitor/fault next state, lamp drive and flash timing.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    fcnt_d  = fcnt_q;
    for (int i = 0; i < 4; i++)
      lamp_d[i] = lamp_q[i];
    unique case (state_q)
      S_MONITOR: begin
        if (code_w != 3'd0) begin
          state_d = S_FAULT;
          code_d  = code_w;
          fcnt_d  = '0;
          for (int i = 0; i < 4; i++)
            lamp_d[i] = RED;
        end else begin
          for (int i = 0; i < 4; i++)
            lamp_d[i] = in_w[i];
        end
      end
      S_FAULT: begin
        if (clr_fault && rcnt_d == RMAX) begin
          state_d = S_MONITOR;
          code_d  = 3'd0;
          fcnt_d  = '0;
          for (int i = 0; i < 4; i++)
            lamp_d[i] = in_w[i];
        end else if (fcnt_q == FMAX) begin
          fcnt_d = '0;
          for (int i = 0; i < 4; i++)
            lamp_d[i] = (lamp_q[0] == RED) ? OFF : RED;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      default: state_d = S_MONITOR;
    endcase
  end

  // State, lamp and fault-cause registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_MONITOR;
      code_q  <= 3'd0;
      fcnt_q  <= '0;
      for (int i = 0; i < 4; i++)
        lamp_q[i] <= RED;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      fcnt_q  <= fcnt_d;
      for (int i = 0; i < 4; i++)
        lamp_q[i] <= lamp_d[i];
    end
  end

  // History and run-length registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        prev_q[i] <= RED;
        ycnt_q[i] <= '0;
      end
    end else begin
      rcnt_q <= rcnt_d;
      for (int i = 0; i < 4; i++) begin
        prev_q[i] <= prev_d[i];
        ycnt_q[i] <= ycnt_d[i];
      end
    end
  end

`ifdef TLC_MON_FAULT_LOG_EN
  logic [7:0] fcount_q;

  // Saturating count of fault entries, kept across recovery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      fcount_q <= 8'd0;
    else if (state_q == S_MONITOR && state_d == S_FAULT
             && fcount_q != 8'hFF)
      fcount_q <= fcount_q + 8'd1;
  end

  assign fault_count = fcount_q;
`endif

  assign lamp_M1    = lamp_q[0];
  assign lamp_M2    = lamp_q[1];
  assign lamp_MT    = lamp_q[2];
  assign lamp_S     = lamp_q[3];
  assign fault      = (state_q == S_FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Bench for tlc_conflict_monitor: directed cases plus random traffic
// checked each cycle against a behavioural model.
module tb_tlc_conflict_monitor;

  localparam int MIN_YELLOW  = 3;
  localparam int FLASH_HALF  = 1;
  localparam int RECOVER_RED = 2;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] lt   [4];
  logic [2:0] lamp [4];
  logic       fault;
  logic [2:0] fcode;
`ifdef TLC_MON_FAULT_LOG_EN
  logic [7:0] fcount;
`endif

  int tests = 0;
  int fails = 0;

  // model state
  logic [2:0] prev  [4];
  int         yrun  [4];
  logic [2:0] elamp [4];
  int         arun   = 0;
  bit         mf     = 1'b0;
  int         mcode  = 0;
  int         ftime  = 0;
  int         ecount = 0;

  always #5 clk = ~clk;

  tlc_conflict_monitor #(
    .MIN_YELLOW (MIN_YELLOW),
    .FLASH_HALF (FLASH_HALF),
    .RECOVER_RED(RECOVER_RED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .light_M1   (lt[0]),
    .light_M2   (lt[1]),
    .light_MT   (lt[2]),
    .light_S    (lt[3]),
    .clr_fault  (clr),
    .lamp_M1    (lamp[0]),
    .lamp_M2    (lamp[1]),
    .lamp_MT    (lamp[2]),
    .lamp_S     (lamp[3]),
    .fault      (fault),
    .fault_code (fcode)
`ifdef TLC_MON_FAULT_LOG_EN
    ,
    .fault_count(fcount)
`endif
  );

  function automatic bit is_valid(logic [2:0] c);
    return (c == R) || (c == Y) || (c == G);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      prev[i]  = R;
      yrun[i]  = 0;
      elamp[i] = R;
    end
    arun   = 0;
    mf     = 1'b0;
    mcode  = 0;
    ftime  = 0;
    ecount = 0;
  endtask

  task automatic model_step();
    bit f1, f2, f3, f4, f5, allred;
    int c;
    f1 = 0; f2 = 0; f3 = 0; f4 = 0; f5 = 0;
    allred = 1;
    for (int i = 0; i < 4; i++) begin
      if (!is_valid(lt[i])) f1 = 1;
      if (prev[i] == G && lt[i] == R) f3 = 1;
      if (prev[i] == Y && lt[i] == R && yrun[i] < MIN_YELLOW) f4 = 1;
      if (prev[i] == Y && lt[i] == G) f5 = 1;
      if (lt[i] != R) allred = 0;
    end
    f2 = (lt[3] == G && (lt[0] == G || lt[1] == G || lt[2] == G))
      || (lt[1] == G && lt[2] == G);
    c = f1 ? 1 : f2 ? 2 : f3 ? 3 : f4 ? 4 : f5 ? 5 : 0;
    arun = allred ? arun + 1 : 0;
    if (!mf) begin
      if (c != 0) begin
        mf = 1; mcode = c; ftime = 0;
        if (ecount < 255) ecount++;
        for (int i = 0; i < 4; i++) elamp[i] = R;
      end else begin
        for (int i = 0; i < 4; i++) elamp[i] = lt[i];
      end
    end else if (clr && arun >= RECOVER_RED) begin
      mf = 0; mcode = 0;
      for (int i = 0; i < 4; i++) elamp[i] = lt[i];
    end else begin
      ftime++;
      for (int i = 0; i < 4; i++)
        elamp[i] = ((ftime / FLASH_HALF) % 2 == 0) ? R : OFF;
    end
    for (int i = 0; i < 4; i++) begin
      yrun[i] = (lt[i] == Y) ? yrun[i] + 1 : 0;
      prev[i] = is_valid(lt[i]) ? lt[i] : R;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    bit bad;
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (lamp[i] !== elamp[i]) bad = 1;
    if (fault !== mf) bad = 1;
    if (fcode !== 3'(mcode)) bad = 1;
`ifdef TLC_MON_FAULT_LOG_EN
    if (fcount !== 8'(ecount)) bad = 1;
`endif
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL cycle_check t=%0t got lamps=%b_%b_%b_%b f=%b c=%0d want lamps=%b_%b_%b_%b f=%b c=%0d",
               $time, lamp[0], lamp[1], lamp[2], lamp[3], fault, fcode,
               elamp[0], elamp[1], elamp[2], elamp[3], mf, mcode);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [2:0] a, input logic [2:0] b,
                     input logic [2:0] c, input logic [2:0] d,
                     input logic cl);
    lt[0] = a; lt[1] = b; lt[2] = c; lt[3] = d;
    clr = cl;
    @(negedge clk);
  endtask

  function automatic logic [2:0] rand_col();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4)  return 3'($urandom_range(0, 7));
    if (r < 40) return R;
    if (r < 70) return Y;
    return G;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) lt[i] = R;
    #12;
    chk("rst_lamp_M1", int'(lamp[0]), 4);
    chk("rst_lamp_S", int'(lamp[3]), 4);
    chk("rst_fault", int'(fault), 0);
    chk("rst_code", int'(fcode), 0);
    @(negedge clk);
    rst = 1'b1;

    // legal phase cycle
    cyc(G, G, R, R, 0);
    chk("legal_m1_g", int'(lamp[0]), 1);
    chk("legal_m2_g", int'(lamp[1]), 1);
    repeat (3) cyc(Y, Y, R, R, 0);
    chk("legal_m1_y", int'(lamp[0]), 2);
    cyc(R, R, R, R, 0);
    chk("legal_red_fault", int'(fault), 0);
    cyc(R, R, R, G, 0);
    chk("legal_s_g", int'(lamp[3]), 1);
    chk("legal_nofault", int'(fault), 0);

    // conflicting greens, flash, interrupted recovery
    cyc(G, R, R, G, 0);
    chk("conf_fault", int'(fault), 1);
    chk("conf_code", int'(fcode), 2);
    chk("conf_lamp_red", int'(lamp[0]), 4);
    cyc(R, R, R, R, 0);
    chk("flash_off", int'(lamp[0]), 0);
    cyc(R, R, R, R, 0);
    chk("flash_red", int'(lamp[2]), 4);
    cyc(G, R, R, R, 1);
    chk("rec_interrupt", int'(fault), 1);
    cyc(R, R, R, R, 1);
    chk("rec_one_red", int'(fault), 1);
    cyc(R, R, R, R, 1);
    chk("rec_fault", int'(fault), 0);
    chk("rec_code", int'(fcode), 0);
    chk("rec_lamp", int'(lamp[1]), 4);

    // short yellow
    cyc(R, G, R, R, 0);
    repeat (2) cyc(R, Y, R, R, 0);
    cyc(R, R, R, R, 0);
    chk("short_y_code", int'(fcode), 4);
    cyc(R, R, R, R, 1);
    chk("short_y_rec", int'(fault), 0);

    // skipped yellow
    cyc(G, R, R, R, 0);
    cyc(R, R, R, R, 0);
    chk("skip_y_code", int'(fcode), 3);
    cyc(R, R, R, R, 1);

    // invalid beats conflict
    cyc(G, R, 3'b011, G, 0);
    chk("invalid_code", int'(fcode), 1);
    cyc(R, R, R, R, 1);
    cyc(R, R, R, R, 1);
    chk("invalid_rec", int'(fault), 0);

    // yellow straight to green
    cyc(R, R, R, Y, 0);
    cyc(R, R, R, G, 0);
    chk("y2g_code", int'(fcode), 5);
    cyc(R, R, R, R, 1);
    cyc(R, R, R, R, 1);

    // asynchronous reset mid-fault
    cyc(G, R, R, G, 0);
    chk("pre_rst_fault", int'(fault), 1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_fault", int'(fault), 0);
    chk("async_rst_lamp", int'(lamp[0]), 4);
    chk("async_rst_code", int'(fcode), 0);
    @(negedge clk);
    rst = 1'b1;

    // two separate faults
    cyc(G, R, R, G, 0);
    cyc(R, R, R, R, 1);
    cyc(R, R, R, R, 1);
    cyc(G, R, R, G, 0);
`ifdef TLC_MON_FAULT_LOG_EN
    chk("fault_count_2", int'(fcount), 2);
`endif
    cyc(R, R, R, R, 1);
    cyc(R, R, R, R, 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (mf && $urandom_range(0, 99) < 60) begin
        for (int i = 0; i < 4; i++) lt[i] = R;
        clr = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 99) >= 65) lt[i] = rand_col();
        clr = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      if (n % 997 == 500) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
